// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: single-port synchronous RAM with valid/ready request port,
// per-byte write enables, address range checking, RD_LAT of 1 or 2 cycles
// and a clear engine that zeroes every word after reset or clr_req.
// Optional feature: define RAM_PARITY_EN for per-byte even parity storage,
// the err_inj port and parity error reporting on rd_err.
module sp_ram_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 100,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              wr_err,
`ifdef RAM_PARITY_EN
    input  logic              err_inj,
`endif
    output logic              init_done
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic [NB-1:0]     par [DEPTH];
    logic [NB-1:0]     wr_par;
    logic [NB-1:0]     rd_par;
`endif

    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_err;

    assign req_ready = (state_q == RUN);
    assign init_done = (state_q == RUN);
    assign accept    = req_valid && (state_q == RUN);
    assign in_range  = ({1'b0, req_addr} < DEPTH_X);
    assign rd_idx    = req_addr[IDX_W-1:0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    // Next state: CLEAR ends after the last word, clr_req restarts it from RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_cnt == LAST) state_d = RUN;
            RUN:     if (clr_req)         state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Clear address counter, parked at 0 outside CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
        end
    end

    // Write port mux: clear engine owns the port in CLEAR, requests in RUN
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_cnt;
        wr_data = '0;
        wr_be   = '1;
`ifdef RAM_PARITY_EN
        wr_par  = '0;
`endif
        if (state_q == RUN) begin
            wr_en   = accept && req_we && in_range;
            wr_idx  = req_addr[IDX_W-1:0];
            wr_data = req_wdata;
            wr_be   = req_be;
`ifdef RAM_PARITY_EN
            for (int unsigned b = 0; b < NB; b++)
                wr_par[b] = (^req_wdata[8*b +: 8]) ^ err_inj;
`endif
        end else begin
            wr_en = 1'b1;
        end
    end

    // Storage array: byte-masked writes, no reset (the clear engine zeroes it)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
`ifdef RAM_PARITY_EN
                    par[wr_idx][b] <= wr_par[b];
`endif
                end
            end
        end
    end

    // Read result before the output register(s)
    always_comb begin
        rd_word = mem[rd_idx];
        s_valid = accept && !req_we;
        s_data  = in_range ? rd_word : '0;
        s_err   = !in_range;
`ifdef RAM_PARITY_EN
        rd_par  = par[rd_idx];
        for (int unsigned b = 0; b < NB; b++)
            if (in_range && ((^rd_word[8*b +: 8]) != rd_par[b]))
                s_err = 1'b1;
`endif
    end

    // Write error pulse, registered on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= accept && req_we && !in_range;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p_valid;
            logic [DATA_W-1:0] p_data;
            logic              p_err;

            // Two-stage read pipeline, flushed by reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_valid  <= 1'b0;
                    p_data   <= '0;
                    p_err    <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                    rd_err   <= 1'b0;
                end else begin
                    p_valid  <= s_valid;
                    p_data   <= s_data;
                    p_err    <= s_err;
                    rd_valid <= p_valid;
                    rd_data  <= p_data;
                    rd_err   <= p_err;
                end
            end
        end else begin : g_lat1
            // Single read output register, flushed by reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                    rd_err   <= 1'b0;
                end else begin
                    rd_valid <= s_valid;
                    rd_data  <= s_data;
                    rd_err   <= s_err;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl (DEPTH=100). Parity checks are included
// when RAM_PARITY_EN is defined.
module tb_sp_ram_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 100;
    localparam int unsigned RD_LAT = 1;

    logic              clk;
    logic              rst_n;
    logic              clr_req;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              wr_err;
    logic              init_done;
`ifdef RAM_PARITY_EN
    logic              err_inj;
`endif

    int ntot  = 0;
    int npass = 0;
    int nfail = 0;
    int cnt;
    int j;

    sp_ram_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .wr_err   (wr_err),
`ifdef RAM_PARITY_EN
        .err_inj  (err_inj),
`endif
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'(addr);
        req_wdata = data;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic rd(input int addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'(addr);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (RD_LAT - 1) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr_req   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
`ifdef RAM_PARITY_EN
        err_inj   = 1'b0;
`endif
        #23;
        check("rst_ready",   {63'd0, req_ready}, 64'd0);
        check("rst_rvalid",  {63'd0, rd_valid},  64'd0);
        check("rst_rdata",   {32'd0, rd_data},   64'd0);
        check("rst_rderr",   {63'd0, rd_err},    64'd0);
        check("rst_wrerr",   {63'd0, wr_err},    64'd0);
        check("rst_initdn",  {63'd0, init_done}, 64'd0);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("init_cycles", 64'(cnt), 64'd100);
        check("init_done",   {63'd0, init_done}, 64'd1);

        // Freshly cleared words
        rd(0);  check("clr_rd0",  {31'd0, rd_err, rd_data}, 64'd0);
                check("clr_rv0",  {63'd0, rd_valid}, 64'd1);
        @(posedge clk); #1;
        check("rv_pulse", {63'd0, rd_valid}, 64'd0);
        rd(57); check("clr_rd57", {31'd0, rd_err, rd_data}, 64'd0);
        rd(99); check("clr_rd99", {31'd0, rd_err, rd_data}, 64'd0);

        // Back-to-back writes 1..7 then reads 0..7
        for (int i = 1; i <= 7; i++) begin
            req_valid = 1'b1; req_we = 1'b1;
            req_addr = 8'(i); req_wdata = 32'(i); req_be = 4'hF;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; req_we = 1'b0;
        check("b2b_wrerr", {63'd0, wr_err}, 64'd0);
        for (int i = 0; i < 8 + int'(RD_LAT) - 1; i++) begin
            if (i < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(i);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            j = i - (int'(RD_LAT) - 1);
            if (j >= 0 && j < 8) begin
                check("b2b_rv",   {63'd0, rd_valid}, 64'd1);
                check("b2b_data", {31'd0, rd_err, rd_data}, 64'(j));
            end else if (j < 0) begin
                check("b2b_rv_lat", {63'd0, rd_valid}, 64'd0);
            end
        end
        req_valid = 1'b0;

        // Byte enables
        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h11223344, 4'b0101);
        rd(5); check("be_merge", {32'd0, rd_data}, 64'hAA22CC44);
        wr(4, 32'hFFFFFFFF, 4'b0000);
        rd(4); check("be_none", {32'd0, rd_data}, 64'd4);

        // Range boundaries
        wr(99, 32'h99, 4'hF);
        check("wr99_err", {63'd0, wr_err}, 64'd0);
        rd(99); check("rd99", {31'd0, rd_err, rd_data}, 64'h99);
        wr(100, 32'h5, 4'hF);
        check("wr100_err", {63'd0, wr_err}, 64'd1);
        wr(102, 32'd130, 4'hF);
        check("wr102_err", {63'd0, wr_err}, 64'd1);
        @(posedge clk); #1;
        check("wrerr_pulse", {63'd0, wr_err}, 64'd0);
        rd(2); check("rd2_intact", {31'd0, rd_err, rd_data}, 64'd2);
        rd(102);
        check("rd102_rv",  {63'd0, rd_valid}, 64'd1);
        check("rd102_dat", {32'd0, rd_data},  64'd0);
        check("rd102_err", {63'd0, rd_err},   64'd1);

        // Write then read same address next cycle
        wr(6, 32'hCAFE0006, 4'hF);
        rd(6); check("wr_rd_fwd", {32'd0, rd_data}, 64'hCAFE0006);

        // clr_req together with a read of addr 3
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3; clr_req = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; clr_req = 1'b0;
        check("clr_ready_lo", {63'd0, req_ready}, 64'd0);
        cnt = 0;
        repeat (RD_LAT - 1) begin @(posedge clk); #1; cnt++; end
        check("clr_rd3_rv",  {63'd0, rd_valid}, 64'd1);
        check("clr_rd3_dat", {31'd0, rd_err, rd_data}, 64'd3);
        while (!req_ready && cnt < 1000) begin @(posedge clk); #1; cnt++; end
        check("clr_cycles", 64'(cnt), 64'd100);
        rd(3); check("clr_rd3_after", {31'd0, rd_err, rd_data}, 64'd0);
        rd(99); check("clr_rd99_after", {32'd0, rd_data}, 64'd0);

        // Reset in the middle of a clear restarts it
        wr(2, 32'h22, 4'hF);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", {63'd0, req_ready}, 64'd0);
        check("rst_mid_rv",    {63'd0, rd_valid},  64'd0);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("rst_mid_cycles", 64'(cnt), 64'd100);
        rd(2); check("rst_mid_rd2", {31'd0, rd_err, rd_data}, 64'd0);

`ifdef RAM_PARITY_EN
        // Parity error injection
        err_inj = 1'b1;
        wr(9, 32'h12345678, 4'hF);
        err_inj = 1'b0;
        rd(9);
        check("par_inj_err", {63'd0, rd_err},  64'd1);
        check("par_inj_dat", {32'd0, rd_data}, 64'h12345678);
        wr(9, 32'h12345678, 4'hF);
        rd(9);
        check("par_ok_err", {63'd0, rd_err},  64'd0);
        check("par_ok_dat", {32'd0, rd_data}, 64'h12345678);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sp_ram_ctrl.md
# sp_ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables, address range checking, configurable read latency and a hardware clear engine. It replaces the fixed 32x100 register-array RAM as the standard on-chip storage block, sitting between a bus master (DMA, CPU data port) and its working memory.

## Interface

- DATA_W, 32, data width in bits; must be a multiple of 8
- ADDR_W, 8, address width
- DEPTH, 100, number of implemented words; 1 <= DEPTH <= 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2

Ports:

- clk  in  1  clock, all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr_req  in  1  one-cycle pulse that restarts the clear engine
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables, writes only
- rd_valid  out  1  rd_data/rd_err valid, one-cycle pulse per read
- rd_data  out  DATA_W  read data
- rd_err  out  1  read error, qualified by rd_valid
- wr_err  out  1  one-cycle pulse: the accepted write was out of range
- init_done  out  1  clear engine finished, RAM in RUN state
- err_inj  in  1  only with RAM_PARITY_EN: corrupt the parity of this write

## Operation

- FSM states are CLEAR and RUN. Reset enters CLEAR.
- CLEAR: a counter walks addresses 0..DEPTH-1 and writes one all-zero word per cycle, with correct parity. req_ready=0 and init_done=0. After the write to DEPTH-1, the FSM goes to RUN and the counter returns to 0.
- RUN: req_ready=1 and init_done=1. A request is accepted on a rising edge where req_valid && req_ready.
- clr_req seen in RUN: the FSM moves to CLEAR on that edge. A request presented in the same cycle is accepted and executed first. Reads already in flight still deliver their rd_valid. clr_req is ignored while in CLEAR.
- Write: only bytes whose req_be bit is 1 are updated. req_be = 0 is a legal no-op.
- Out-of-range is defined as req_addr >= DEPTH.
  - Out-of-range write: memory is unchanged and wr_err pulses.
  - Out-of-range read: rd_data = 0 and rd_err = 1.
- Reset values: req_ready=0, rd_valid=0, rd_data=0, rd_err=0, wr_err=0, init_done=0. Memory contents are not reset directly; the clear engine handles them.
- Reset asserted mid-operation: the read pipeline is flushed and the FSM returns to CLEAR. A partially completed clear restarts from address 0.

## Timing

- Edge N is the edge on which a request is accepted.
- RD_LAT=1: rd_valid, rd_data and rd_err are registered on edge N and held for one cycle.
- RD_LAT=2: one extra output register; the result is visible after edge N+1.
- Back-to-back requests are sustained at one per cycle in RUN, with no bubbles.
- Write then read of the same address on the next cycle returns the new data (no stale read).
- wr_err is registered on edge N and lasts one cycle.
- Leaving reset: the first clear write happens on the first edge after rst_n rises. req_ready rises after DEPTH edges.
- clr_req: req_ready is low from the cycle after edge N for DEPTH cycles.

## Configuration

- RAM_PARITY_EN defined:
  - each byte stores one even-parity bit, written from the masked write data;
  - port err_inj exists, and err_inj=1 on an accepted write inverts all stored parity bits of the written bytes;
  - on a read, any parity mismatch sets rd_err=1 while the stored rd_data is still presented.
- RAM_PARITY_EN undefined:
  - no parity storage and no err_inj port;
  - rd_err reports out-of-range reads only.

## Test plan

- Reset with DEPTH=100, then release: req_ready=0 for 100 cycles and then 1. Reading addresses 0, 57 and 99 returns 0 with rd_err=0.
- Write addr 1..7 with data 1..7 and req_be=all ones, then read 0..7: the results are 0,1,...,7. With RD_LAT=1, rd_valid follows each accept edge by 0 cycles; with RD_LAT=2, by 1 cycle.
- Write 0xAABBCCDD to addr 5, then write 0x11223344 with req_be=4'b0101, then read: the result is 0xAA22CC44.
- Write addr 102 data 130: wr_err pulses and addr 2 still reads 2. Reading addr 102 gives rd_valid=1, rd_data=0, rd_err=1.
- Issue clr_req with a read of addr 3 in the same cycle: rd_data=3 is delivered, req_ready is low for 100 cycles, and addr 3 then reads 0. Asserting rst_n mid-clear restarts the 100-cycle clear.
- With RAM_PARITY_EN: write addr 9 with err_inj=1, then read: rd_err=1 and the data is intact. Rewrite addr 9 with err_inj=0, then read: rd_err=0.
